softmax_host_ctrl: RTL and testbench

Host-side driver for the softmax core's external BRAM ports. It accepts a row stream of 64-bit beats and packs every 16 beats plus a 4-bit mode into one 1028-bit BRAM row. It then pulses start, waits for the core to finish, and streams the result rows back out as 64-bit beats. It sits between a host stream interface and the softmax core, and drives the core's port A, port B, start and depth inputs.

---
 rtl/softmax_host_ctrl.sv | 138 +++++++++++++
 tb/tb_softmax_host_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_host_ctrl.sv
// softmax_host_ctrl: packs host beats into BRAM rows, runs the softmax core, streams result rows back.
// Optional busy watchdog enabled by defining SOFTMAX_HOST_WATCHDOG_EN.
module softmax_host_ctrl #(
    parameter int BEATS  = 16,
    parameter int TO_CYC = 1048576
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_s_valid,
    output logic          o_s_ready,
    input  logic [63:0]   i_s_data,
    input  logic [3:0]    i_s_mode,
    input  logic          i_s_last,
    output logic          o_m_valid,
    input  logic          i_m_ready,
    output logic [63:0]   o_m_data,
    output logic          o_m_last,
    output logic          o_done,
    output logic          o_err,
    output logic          o_core_en,
    output logic          o_core_start,
    output logic [7:0]    o_core_depth,
    input  logic          i_core_busy,
    output logic          o_ext_cena,
    output logic          o_ext_wea,
    output logic [7:0]    o_ext_addra,
    output logic [1027:0] o_ext_dina,
    output logic          o_ext_cenb,
    output logic [7:0]    o_ext_addrb,
    input  logic [1027:0] i_ext_doutb
);
    typedef enum logic [2:0] {LOAD, WR, START, WAIT_HI, WAIT_LO, RD_REQ, RD_CAP, DRAIN} state_t;
    state_t state, state_nx;
    logic en, last_q, done_q, to_hit, s_hs, m_hs, row_end;
    logic [3:0] b, k, mode_q;
    logic [7:0] r, a;
    logic [BEATS-2:0][63:0] beats;
    logic [1023:0] obuf;

    assign o_core_en    = en;
    assign o_s_ready    = en && state == LOAD;
    assign s_hs         = o_s_ready && i_s_valid;
    assign o_m_valid    = state == DRAIN;
    assign m_hs         = o_m_valid && i_m_ready;
    assign row_end      = m_hs && k == 4'(BEATS - 1);
    assign o_m_data     = obuf[63:0];
    assign o_m_last     = o_m_valid && k == 4'(BEATS - 1) && a == r;
    assign o_done       = done_q;
    assign o_core_start = state == START;
    assign o_core_depth = r;
    assign o_ext_cena   = state == WR;
    assign o_ext_wea    = state == WR;
    assign o_ext_cenb   = state == RD_REQ;
    assign o_ext_addrb  = a;

`ifdef SOFTMAX_HOST_WATCHDOG_EN
    logic [20:0] wd;
    logic err_q;
    assign o_err  = err_q;
    assign to_hit = (state == WAIT_HI && !i_core_busy && wd == 21'd15) ||
                    (state == WAIT_LO && i_core_busy && wd == 21'(TO_CYC - 1));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            wd    <= (state == WAIT_HI && !i_core_busy) || (state == WAIT_LO && i_core_busy) ? wd + 21'd1 : '0;
            err_q <= s_hs && b == 4'd0 && r == 8'd0 ? 1'b0 : to_hit ? 1'b1 : err_q;
        end
    end
`else
    assign to_hit = 1'b0;
    assign o_err  = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= LOAD;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = s_hs && b == 4'(BEATS - 1) ? WR : LOAD;
            WR:      state_nx = last_q ? START : LOAD;
            START:   state_nx = WAIT_HI;
            WAIT_HI: state_nx = to_hit ? LOAD : i_core_busy ? WAIT_LO : WAIT_HI;
            WAIT_LO: state_nx = to_hit ? LOAD : i_core_busy ? WAIT_LO : RD_REQ;
            RD_REQ:  state_nx = RD_CAP;
            RD_CAP:  state_nx = DRAIN;
            DRAIN:   state_nx = !row_end ? DRAIN : a == r ? LOAD : RD_REQ;
            default: state_nx = LOAD;
        endcase
    end

    // Beats 0..14 shift into the buffer; beat 15 completes the row directly into the port A register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en          <= 1'b0;
            done_q      <= 1'b0;
            last_q      <= 1'b0;
            b           <= '0;
            k           <= '0;
            mode_q      <= '0;
            r           <= '0;
            a           <= '0;
            beats       <= '0;
            obuf        <= '0;
            o_ext_addra <= '0;
            o_ext_dina  <= '0;
        end else begin
            en     <= 1'b1;
            done_q <= o_m_last && i_m_ready;
            if (s_hs) begin
                b     <= b + 4'd1;
                beats <= {i_s_data, beats[BEATS-2:1]};
                if (b == 4'd0) mode_q <= i_s_mode;
                if (b == 4'(BEATS - 1)) begin
                    o_ext_dina  <= {mode_q, i_s_data, beats};
                    o_ext_addra <= r;
                    last_q      <= i_s_last || r == 8'hFF;
                end
            end
            if (state == WR && !last_q) r <= r + 8'd1;
            if (state == WAIT_LO && !i_core_busy) a <= '0;
            if (state == RD_CAP) obuf <= i_ext_doutb[1023:0];
            if (m_hs) begin
                k    <= k + 4'd1;
                obuf <= {64'd0, obuf[1023:64]};
            end
            if (row_end) begin
                if (a == r) r <= '0;
                else a <= a + 8'd1;
            end
            if (to_hit) r <= '0;
        end
    end
endmodule

// File: tb/tb_softmax_host_ctrl.sv
// tb_softmax_host_ctrl: directed bench with BRAM and busy models for softmax_host_ctrl.
module tb_softmax_host_ctrl;
    logic          i_clk = 1'b0, i_rst_n = 1'b0;
    logic          i_s_valid = 1'b0, i_s_last = 1'b0, i_m_ready = 1'b1, i_core_busy = 1'b0;
    logic [63:0]   i_s_data = '0;
    logic [3:0]    i_s_mode = '0;
    logic          o_s_ready, o_m_valid, o_m_last, o_done, o_err, o_core_en, o_core_start;
    logic          o_ext_cena, o_ext_wea, o_ext_cenb;
    logic [63:0]   o_m_data;
    logic [7:0]    o_core_depth, o_ext_addra, o_ext_addrb;
    logic [1027:0] o_ext_dina, i_ext_doutb = '0;
    logic [1027:0] mem [256];
    logic [7:0]    rdq [$];
    int            errors = 0, checks = 0, busy_len = 5, bcnt = 0, idx;
    logic          start_seen = 1'b0, rdy_seen, stalled, done_seen;
    logic [63:0]   held;

    softmax_host_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
        .i_s_data(i_s_data), .i_s_mode(i_s_mode), .i_s_last(i_s_last), .o_m_valid(o_m_valid),
        .i_m_ready(i_m_ready), .o_m_data(o_m_data), .o_m_last(o_m_last), .o_done(o_done),
        .o_err(o_err), .o_core_en(o_core_en), .o_core_start(o_core_start),
        .o_core_depth(o_core_depth), .i_core_busy(i_core_busy), .o_ext_cena(o_ext_cena),
        .o_ext_wea(o_ext_wea), .o_ext_addra(o_ext_addra), .o_ext_dina(o_ext_dina),
        .o_ext_cenb(o_ext_cenb), .o_ext_addrb(o_ext_addrb), .i_ext_doutb(i_ext_doutb)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_ext_cena && o_ext_wea) mem[o_ext_addra] <= o_ext_dina;
        if (o_ext_cenb) begin
            i_ext_doutb <= mem[o_ext_addrb];
            rdq.push_back(o_ext_addrb);
        end
    end

    // Busy rises in the cycle after the start pulse and stays high for busy_len cycles.
    always @(negedge i_clk) begin
        if (start_seen) bcnt = busy_len;
        else if (bcnt > 0) bcnt = bcnt - 1;
        i_core_busy = bcnt > 0;
        start_seen = o_core_start;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    function automatic logic [63:0] pat(input int j, input int k);
        return {32'(j), 32'(k + 1)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_row(input logic [3:0] mode, input int j, input logic last);
        for (int k = 0; k < 16; k++) begin
            int t = 0;
            i_s_valid = 1'b1;
            i_s_data  = pat(j, k);
            i_s_mode  = k == 0 ? mode : ~mode;
            i_s_last  = k == 15 ? last : 1'b1;
            while (!o_s_ready && t < 5000) begin
                @(negedge i_clk);
                t++;
            end
            if (!o_s_ready) check("s_ready_timeout", o_s_ready, 1);
            @(negedge i_clk);
        end
        i_s_valid = 1'b0;
        i_s_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!o_m_valid && t < 5000) begin
            @(negedge i_clk);
            t++;
        end
        if (!o_m_valid) check("m_valid_timeout", o_m_valid, 1);
    endtask

    task automatic drain(input int nrows);
        rdy_seen = 1'b0;
        for (int j = 0; j < nrows; j++)
            for (int k = 0; k < 16; k++) begin
                wait_valid();
                rdy_seen = rdy_seen | o_s_ready;
                check("m_data", o_m_data, pat(j, k));
                check("m_last", o_m_last, 64'(j == nrows - 1 && k == 15));
                if (j == nrows - 1 && k == 15) i_s_valid = 1'b0;
                @(negedge i_clk);
            end
        check("done", o_done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {o_s_ready, o_m_valid, o_m_last, o_done, o_err, o_core_en,
                              o_core_start, o_ext_cena, o_ext_wea, o_ext_cenb}, 0);
        check({tag, "_mdata"}, o_m_data, 0);
        check({tag, "_addr"}, {o_ext_addra, o_ext_addrb, o_core_depth}, 0);
        check({tag, "_dina_lo"}, o_ext_dina[63:0], 0);
        check({tag, "_dina_hi"}, o_ext_dina[1027:964], 0);
    endtask

    initial begin
        @(negedge i_clk);
        check_all_zero("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_reset", o_s_ready, 1);
        check("core_en_after_reset", o_core_en, 1);

        // one row, mode 3, data k+1
        send_row(4'h3, 0, 1'b1);
        check("wr_en", {o_ext_cena, o_ext_wea, o_s_ready}, 3'b110);
        check("wr_addra", o_ext_addra, 0);
        check("wr_mode", o_ext_dina[1027:1024], 3);
        check("wr_beat0", o_ext_dina[63:0], 1);
        check("wr_beat15", o_ext_dina[1023:960], 16);
        @(negedge i_clk);
        check("start", o_core_start, 1);
        check("depth1", o_core_depth, 0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge i_clk);
            if (i == 1) check("start_pulse", o_core_start, 0);
            if (i == 7) check("rd_req", {o_ext_cenb, o_ext_addrb}, {1'b1, 8'd0});
            if (i == 8) check("valid_early", o_m_valid, 0);
            if (i == 9) check("valid_latency", o_m_valid, 1);
        end
        drain(1);
        check("ready_after_done", o_s_ready, 1);

        // three rows
        rdq.delete();
        for (int j = 0; j < 3; j++) send_row(4'(j), j, j == 2);
        @(negedge i_clk);
        check("depth3", o_core_depth, 2);
        drain(3);
        check("rd_count", rdq.size(), 3);
        for (int j = 0; j < 3; j++) check("rd_addr", rdq[j], j);

        // output backpressure
        send_row(4'h2, 0, 1'b1);
        i_m_ready = 1'b0;
        idx = 0;
        stalled = 1'b0;
        for (int t = 0; t < 400 && idx < 16; t++) begin
            i_m_ready = ~i_m_ready;
            if (o_m_valid) begin
                if (stalled) check("stall_hold", o_m_data, held);
                if (i_m_ready) begin
                    check("bp_data", o_m_data, pat(0, idx));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    held = o_m_data;
                    stalled = 1'b1;
                end
            end
            @(negedge i_clk);
        end
        check("bp_count", idx, 16);
        check("bp_done", o_done, 1);
        i_m_ready = 1'b1;

        // 256 rows without last
        for (int j = 0; j < 255; j++) send_row(4'(j), j, 1'b0);
        send_row(4'hF, 255, 1'b0);
        check("wr255", {o_ext_cena, o_ext_addra}, {1'b1, 8'hFF});
        @(negedge i_clk);
        check("start256", o_core_start, 1);
        check("depth256", o_core_depth, 8'hFF);
        i_s_valid = 1'b1;
        drain(256);
        check("ready_held_low", rdy_seen, 0);
        check("ready_after_256", o_s_ready, 1);

        // reset during drain of row 1
        send_row(4'h1, 0, 1'b0);
        send_row(4'h1, 1, 1'b1);
        for (int i = 0; i < 19; i++) begin
            wait_valid();
            @(negedge i_clk);
        end
        check("in_drain", o_m_valid, 1);
        i_rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_abort", o_s_ready, 1);
        send_row(4'h5, 0, 1'b1);
        check("addra_after_abort", {o_ext_cena, o_ext_addra}, {1'b1, 8'd0});
        drain(1);

`ifdef SOFTMAX_HOST_WATCHDOG_EN
        busy_len = 0;
        done_seen = 1'b0;
        send_row(4'h1, 0, 1'b1);
        @(negedge i_clk);
        check("wd_start", o_core_start, 1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge i_clk);
            done_seen = done_seen | o_done;
        end
        check("wd_err_early", o_err, 0);
        @(negedge i_clk);
        check("wd_err", o_err, 1);
        check("wd_ready", o_s_ready, 1);
        repeat (4) begin
            @(negedge i_clk);
            done_seen = done_seen | o_done;
        end
        check("wd_no_done", done_seen, 0);
        check("wd_err_sticky", o_err, 1);
        busy_len = 5;
        send_row(4'h1, 0, 1'b1);
        check("wd_err_clear", o_err, 0);
        drain(1);
`else
        check("err_tied", o_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
